// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MIPS32 load/store controller for word-organised data memory.
// Loads do lane extraction and extension; sub-word stores do read-modify-write.
module dm_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic we_q, sx_q, illegal, sub_store;
  logic [1:0] size_q;
  logic [4:0] sh;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [DATA_W-1:0] wdata_q, merge_q, load_val, merge_val, lane_mask, lane_data;
  always_comb begin
    illegal = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    sub_store = we_q && size_q != 2'b10;
    sh = size_q == 2'b01 ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    byte_v = 8'(mem_dout >> sh);
    half_v = 16'(mem_dout >> sh);
    load_val = size_q == 2'b00 ? {{24{sx_q & byte_v[7]}}, byte_v} :
               size_q == 2'b01 ? {{16{sx_q & half_v[15]}}, half_v} : mem_dout;
    lane_mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    lane_data = (size_q == 2'b00 ? {24'b0, wdata_q[7:0]} : {16'b0, wdata_q[15:0]}) << sh;
    merge_val = (mem_dout & ~lane_mask) | lane_data;
    state_d = state_q == IDLE   ? (req && !illegal ? ACCESS : IDLE) :
              state_q == ACCESS ? (sub_store ? WRITE : IDLE) : IDLE;
    busy = state_q != IDLE;
    mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    mem_din = state_q == WRITE ? merge_q : wdata_q;
    // clr gates the strobe combinationally so an aborted WRITE never reaches memory
    mem_wr = !clr && (state_q == WRITE || (state_q == ACCESS && we_q && size_q == 2'b10));
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      sx_q <= 1'b0;
      size_q <= 2'b00;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      done <= (state_q == IDLE && req && illegal) || (state_q == ACCESS && !sub_store) || state_q == WRITE;
      err <= state_q == IDLE && req && illegal;
      if (state_q == IDLE && req && !illegal) begin
        addr_q <= addr;
        we_q <= we;
        size_q <= size;
        sx_q <= sign_ext;
        wdata_q <= wdata;
      end
      if (state_q == ACCESS && !we_q) rdata <= load_val;
      if (state_q == ACCESS) merge_q <= merge_val;
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and random load/store checks against a word-array reference model.
module tb_dm_access_ctrl;
  logic clk = 0, clr = 1, req = 0, we = 0, sign_ext = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic done, err, busy, mem_wr;
  int compared = 0, mismatched = 0;
  logic [31:0] tb_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] m_rdata = 0;
  logic pre_en = 0;
  logic [3:0] pre_idx = 0;
  logic [31:0] pre_val = 0;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout)
  );

  assign mem_dout = tb_mem[mem_addr[5:2]];
  always @(posedge clk)
    if (mem_wr) tb_mem[mem_addr[5:2]] <= mem_din;
    else if (pre_en) tb_mem[pre_idx] <= pre_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1; pre_idx = i[3:0]; pre_val = v;
    @(negedge clk);
    pre_en = 0;
    ref_mem[i] = v;
  endtask

  function automatic logic f_ill(input logic [1:0] s, input logic [31:0] a);
    return s == 3 || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [31:0] a, input logic [1:0] s, input logic sx);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    if (s == 0) return (sx && b >= 128) ? b + 32'hFFFFFF00 : b;
    if (s == 1) return (sx && h >= 32768) ? h + 32'hFFFF0000 : h;
    return w;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [7:0] by [4];
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    if (s == 2) return d;
    if (s == 0) by[a[1:0]] = d[7:0];
    else begin
      by[2 * a[1]] = d[7:0];
      by[2 * a[1] + 1] = d[15:8];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic op(input logic w, input logic [1:0] s, input logic sx, input logic [31:0] a, input logic [31:0] d);
    logic ill;
    int exp_lat, lat, wrs, bsy, idx;
    logic [31:0] exp_word, din_seen;
    idx = int'(a[5:2]);
    ill = f_ill(s, a);
    exp_lat = ill ? 1 : (!w || s == 2) ? 2 : 3;
    exp_word = (w && !ill) ? f_store(ref_mem[idx], a, s, d) : ref_mem[idx];
    if (!w && !ill) m_rdata = f_load(ref_mem[idx], a, s, sx);
    @(negedge clk);
    req = 1; we = w; size = s; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 0;
    if (!ill) chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
    lat = 1; wrs = 0; bsy = 0; din_seen = exp_word;
    while (!done && lat < 8) begin
      if (mem_wr) begin wrs++; din_seen = mem_din; end
      bsy += int'(busy);
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, exp_lat);
    chk("err", err, ill);
    chk("rdata", rdata, m_rdata);
    chk("writes", wrs, (w && !ill) ? 1 : 0);
    chk("busy_cycles", bsy, exp_lat - 1);
    chk("mem_din", din_seen, exp_word);
    chk("mem_word", tb_mem[idx], exp_word);
    ref_mem[idx] = exp_word;
    @(posedge clk);
    #1 chk("pulse", {done, err}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic [31:0] da, db, ea, eb;
    repeat (2) @(posedge clk);
    #1 chk("reset_rdata", rdata, 0);
    chk("reset_flags", {done, err, busy, mem_wr}, 0);
    clr = 0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);

    preload(8, 0);
    op(1, 2, 0, 32'h20, 32'hDEADBEEF);
    op(0, 2, 0, 32'h20, 0);
    chk("lw_value", rdata, 32'hDEADBEEF);
    preload(8, 32'h11223344);
    op(1, 0, 0, 32'h21, 32'h5A);
    chk("sb_value", tb_mem[8], 32'h11225A44);
    preload(8, 32'h0080FF00);
    op(0, 0, 1, 32'h22, 0);
    chk("lb_value", rdata, 32'hFFFFFF80);
    op(0, 0, 0, 32'h22, 0);
    chk("lbu_value", rdata, 32'h00000080);
    op(0, 1, 1, 32'h22, 0);
    chk("lh_value", rdata, 32'h00000080);
    op(0, 1, 0, 32'h20, 0);
    chk("lhu_value", rdata, 32'h0000FF00);
    op(0, 2, 0, 32'h23, 0);
    op(1, 1, 0, 32'h21, 32'h1234);
    op(0, 3, 0, 32'h20, 0);

    preload(4, 32'hAABBCCDD);
    @(negedge clk);
    req = 1; we = 1; size = 0; addr = 32'h10; wdata = 32'h11;
    @(posedge clk);
    #1 req = 0;
    @(posedge clk);
    #1 chk("rst_inwrite", {busy, mem_wr}, 2'b11);
    clr = 1;
    #1 chk("rst_wr_gate", mem_wr, 0);
    @(posedge clk);
    #1 chk("rst_wr1", {mem_wr, done}, 0);
    @(posedge clk);
    #1 chk("rst_wr2", {mem_wr, done, busy}, 0);
    chk("rst_rdata", rdata, 0);
    clr = 0;
    m_rdata = 0;
    chk("rst_word", tb_mem[4], 32'hAABBCCDD);

    da = $urandom; db = $urandom;
    ea = f_store(ref_mem[12], 32'h30, 1, da);
    eb = f_store(ref_mem[13], 32'h34, 1, db);
    @(negedge clk);
    req = 1; we = 1; size = 1; sign_ext = 0; addr = 32'h30; wdata = da;
    @(posedge clk);
    #1 lat = 1;
    while (!done && lat < 8) begin @(posedge clk); #1 lat++; end
    chk("b2b_lat1", lat, 3);
    addr = 32'h34; wdata = db;
    @(posedge clk);
    #1 chk("b2b_accept", busy, 1);
    req = 1; we = 0; size = 2; addr = 32'h30;
    @(posedge clk);
    #1 req = 0;
    lat = 2;
    while (!done && lat < 8) begin @(posedge clk); #1 lat++; end
    chk("b2b_lat2", lat, 3);
    chk("b2b_rdata", rdata, m_rdata);
    n = 0;
    repeat (4) begin @(posedge clk); #1 n += int'(done); end
    chk("b2b_extra", n, 0);
    chk("b2b_word1", tb_mem[12], ea);
    chk("b2b_word2", tb_mem[13], eb);
    ref_mem[12] = ea; ref_mem[13] = eb;

    for (int i = 0; i < 200; i++)
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 63)), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Load/store access controller between the MIPS32 datapath and the 4 KB word-organised data memory. It takes one request per transaction (LB/LBU/LH/LHU/LW/SB/SH/SW), performs byte-lane extraction and sign/zero extension for loads, and does read-modify-write for sub-word stores, because the data memory only supports full-word writes. It detects misaligned and illegal accesses and reports completion with a one-cycle done pulse.

Parameters:
ADDR_W, 32, width of the address from the datapath and to memory
DATA_W, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
clk       in   1   clock, all state updates on rising edge
clr       in   1   reset, synchronous, active-high
req       in   1   request strobe, sampled only in IDLE
we        in   1   1 = store, 0 = load
size      in   2   00 byte, 01 half, 10 word, 11 illegal
sign_ext  in   1   loads only: 1 = sign-extend, 0 = zero-extend
addr      in   32  byte address
wdata     in   32  store data; byte/half taken from low bits
rdata     out  32  load result, registered
done      out  1   one-cycle completion pulse, registered
err       out  1   one-cycle misalign/illegal pulse, coincident with done
busy      out  1   state != IDLE
mem_addr  out  32  to data memory: latched addr with [1:0] = 00
mem_din   out  32  to data memory write data
mem_wr    out  1   to data memory write enable
mem_dout  in   32  from data memory, combinational read of mem_addr

Behaviour:
- Reset (clr=1 at edge): state to IDLE; rdata=0, done=0, err=0, internal latches=0. mem_wr is forced 0 while clr=1. Reset aborts any transaction in flight: no write, no done.
- Lane map is little-endian: byte n (addr[1:0]=n) is bits [8n+7:8n]; the half at addr[1]=h is bits [16h+15:16h].
- Alignment: size=01 with addr[0]=1, size=10 with addr[1:0]!=00, or size=11 is an error. An error request in IDLE causes no state change and no memory access. On the next edge done=1 and err=1 for one cycle, and rdata holds its value.
- FSM states are IDLE, ACCESS, WRITE.
- IDLE: when req=1 and the request is legal, latch addr, we, size, sign_ext and wdata, then go to ACCESS. req in any other state is ignored and not queued.
- ACCESS, load: extract the lane from mem_dout and extend to 32 bits. At the edge, rdata receives the result, done=1, and the state goes to IDLE.
- ACCESS, store word: mem_wr=1 and mem_din=wdata during this cycle (memory writes at the edge). done=1 at the edge, then IDLE.
- ACCESS, store byte/half: mem_wr=0. Merge the new lane into mem_dout and register the result in merge_q, then go to WRITE.
- WRITE: mem_wr=1, mem_din=merge_q. done=1 at the edge, then IDLE.
- Outside ACCESS and WRITE, mem_wr=0. mem_din equals wdata_q in ACCESS and merge_q in WRITE.
- Latency, counting the req-sampling edge as E0: load and SW give done after E2; SB/SH give done after E3.
- done and err are high exactly one cycle. busy is high in ACCESS and WRITE.
- Back-to-back: req may be asserted in the cycle done is high, because the state is already IDLE. A read following a store sees the stored data.
- Extension: LB uses bit 7 and LH uses bit 15 of the selected lane when sign_ext=1. Otherwise the upper bits are 0. sign_ext is ignored for word loads and for all stores.

Test Plan:
- Reset: hold clr 2 cycles mid-WRITE of an SB to 0x10 holding 0xAABBCCDD -> mem_wr never sampled high, done=0, rdata=0, busy=0, word unchanged.
- SW 0xDEADBEEF to 0x20, then LW 0x20 -> write at E1→E2, done after E2, then rdata=0xDEADBEEF with done pulse 2 edges after the load req.
- SB 0x5A to 0x21 with the word holding 0x11223344 -> word becomes 0x11225A44, done after E3, busy high 2 cycles.
- LB 0x22 sign_ext=1 on word 0x0080FF00 -> rdata=0xFFFFFF80; LBU same address -> 0x00000080; LH 0x22 sign_ext=1 -> 0x00000080; LHU 0x20 -> 0x0000FF00.
- Misaligned LW at 0x23, SH at 0x21, and size=11 -> each yields done=err=1 one edge later, no mem_wr, rdata unchanged, busy stays 0.
- req held high continuously across an SH sequence -> second request accepted only in the cycle done=1, no request lost or duplicated; a req pulse during busy is ignored.
